pci_rr_arbiter: RTL
===================

Name: pci_rr_arbiter

Overview:
- Parametrised central PCI bus arbiter for N_MASTERS Device_Controller instances sharing frame/irdy/AD.
- Replaces the fixed 4-master arbiter with:
  - round-robin fairness;
  - bus-idle-qualified grant hand-off with a mandatory one-cycle grant gap;
  - grant preemption while another master is waiting;
  - a no-start timeout.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..16).
- TIMEOUT, 16, cycles a granted master may hold gnt without asserting frame before the grant is revoked (≥2).
- PARK_MASTER, 0, master index parked on when idle (used only with ARB_PARK_EN).
- OWNER_W, localparam = max(1, clog2(N_MASTERS)).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  N_MASTERS  request per master, active-low (bit i = master i)
- frame  in  1  PCI frame#, active-low, idle-high
- irdy  in  1  PCI irdy#, active-low, idle-high
- gnt  out  N_MASTERS  grant per master, active-low, registered; at most one bit low
- owner  out  OWNER_W  index of the current/last granted master
- owner_valid  out  1  high while any gnt bit is low
- timeout  out  1  one-cycle pulse when a grant is revoked for no-start

Behaviour:
- Bus idle: frame=1 and irdy=1 sampled at the same edge.
- All outputs are registered.
- Reset (synchronous, dominates everything, including mid-transaction):
  - outputs: gnt all 1, owner=0, owner_valid=0, timeout=0;
  - internal: ptr=0, counter=0, state IDLE.
- IDLE:
  - Any req bit low → winner = first low req bit searching ptr, ptr+1, … mod N_MASTERS.
  - Next edge: gnt[winner]=0, owner=winner, owner_valid=1, counter=0 → GRANTED.
  - Arbitration in IDLE does not require bus idle; the granted master itself waits for idle before driving frame.
- GRANTED (gnt held, counter increments each cycle):
  - frame sampled low → BUSY; ptr=(owner+1) mod N_MASTERS.
  - Else req[owner] returns high → release gnt next edge → IDLE; ptr unchanged.
  - Else counter reaches TIMEOUT-1 → release gnt, timeout=1 for one cycle, ptr=(owner+1) mod N_MASTERS → IDLE.
  - If frame low and req[owner] high occur together, frame wins (→ BUSY).
- BUSY:
  - Any req bit other than owner low → gnt[owner] deasserted next edge (preemption). owner_valid follows gnt and drops with it. The master completes its current transaction; state stays BUSY.
  - No other request → gnt[owner] held (back-to-back transactions by the owner are allowed).
  - Bus idle sampled → release gnt (if still held) → IDLE.
- Grant gap: entering IDLE always gives one full cycle with gnt all 1 before any new grant. No two masters are ever granted in consecutive cycles.
- Round robin: ptr only advances as specified above. A master whose req is high is skipped by the search.
- req/frame/irdy are sampled synchronously; X on req while in reset is ignored.

Optional Feature:
- Macro: ARB_PARK_EN.
- Defined:
  - IDLE with all req high (after the mandatory gap cycle) → gnt[PARK_MASTER]=0, owner=PARK_MASTER, owner_valid=1 (parked).
  - The parked grant is exempt from the timeout.
  - If the park master asserts frame → BUSY as normal.
  - If any other req goes low → park gnt released next edge, one-cycle gap, then normal arbitration.
- Not defined: gnt stays all 1 while no request is pending.

Test Plan:
1. Reset, req=4'b1111, frame=irdy=1 → gnt=4'b1111, owner_valid=0, timeout=0 for 10 cycles.
2. req=4'b1110 → gnt=4'b1110 one edge later. frame=0 for 3 cycles, then frame=irdy=1 → gnt=4'b1111 for ≥1 cycle, ptr=1.
3. After test 2, req=4'b1010 → gnt=4'b1011 (master 2 wins from ptr=1). Complete the transaction; next grant 4'b1110 (master 0) after a one-cycle all-1 gap.
4. req=4'b1101, frame held 1 → gnt=4'b1101 for 16 cycles, then gnt=4'b1111 with a single-cycle timeout pulse. Next search starts at master 2.
5. Master 1 in BUSY (frame=0), req[3] goes low → gnt[1] high next edge while frame stays 0. After frame=irdy=1 → gap cycle, then gnt=4'b0111.
6. With ARB_PARK_EN, PARK_MASTER=2, all req high → gnt=4'b1011 after the gap. req[0] low → gnt=4'b1111 for one cycle, then 4'b1110.

Source files
------------

// File: rtl/pci_rr_arbiter.sv
// Round-robin central PCI bus arbiter with bus-idle-qualified hand-off, preemption and no-start timeout.
// Optional grant parking on PARK_MASTER is enabled by defining ARB_PARK_EN.
module pci_rr_arbiter #(
  parameter  int unsigned N_MASTERS   = 4,
  parameter  int unsigned TIMEOUT     = 16,
  parameter  int unsigned PARK_MASTER = 0,
  localparam int unsigned OWNER_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 frame,
  input  logic                 irdy,
  output logic [N_MASTERS-1:0] gnt,
  output logic [OWNER_W-1:0]   owner,
  output logic                 owner_valid,
  output logic                 timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef logic [OWNER_W-1:0] owner_t;
  typedef logic [OWNER_W:0]   ext_t;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef enum logic [1:0] {IDLE, GRANTED, BUSY, PARKED} state_t;

`ifdef ARB_PARK_EN
  localparam owner_t PARK_IDX = owner_t'(PARK_MASTER);
`endif

  state_t               state, state_n;
  owner_t               ptr, ptr_n, owner_n, winner, owner_inc;
  cnt_t                 counter, counter_n;
  logic [N_MASTERS-1:0] gnt_n, others;
  logic                 owner_valid_n, timeout_n;
  logic                 any_req, other_req, bus_idle;
  ext_t                 sum;

  assign bus_idle  = frame & irdy;
  assign owner_inc = (owner == owner_t'(N_MASTERS - 1)) ? '0 : owner + 1'b1;

  // First low request found scanning ptr, ptr+1, ... with wrap-around.
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    sum     = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      sum = ext_t'(ptr) + ext_t'(i);
      if (sum >= ext_t'(N_MASTERS)) sum = sum - ext_t'(N_MASTERS);
      if (!any_req && !req[owner_t'(sum)]) begin
        winner  = owner_t'(sum);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    others        = ~req;
    others[owner] = 1'b0;
    other_req     = |others;
  end

  always_comb begin
    state_n       = state;
    gnt_n         = gnt;
    owner_n       = owner;
    owner_valid_n = owner_valid;
    timeout_n     = 1'b0;
    ptr_n         = ptr;
    counter_n     = counter;
    case (state)
      // Every entry into IDLE releases gnt, so this state is itself the gap cycle.
      IDLE: begin
        if (any_req) begin
          gnt_n         = '1;
          gnt_n[winner] = 1'b0;
          owner_n       = winner;
          owner_valid_n = 1'b1;
          counter_n     = '0;
          state_n       = GRANTED;
        end
`ifdef ARB_PARK_EN
        else begin
          gnt_n           = '1;
          gnt_n[PARK_IDX] = 1'b0;
          owner_n         = PARK_IDX;
          owner_valid_n   = 1'b1;
          state_n         = PARKED;
        end
`endif
      end
      GRANTED: begin
        if (!frame) begin
          state_n = BUSY;
          ptr_n   = owner_inc;
        end else if (req[owner]) begin
          gnt_n         = '1;
          owner_valid_n = 1'b0;
          state_n       = IDLE;
        end else if (counter == cnt_t'(TIMEOUT - 1)) begin
          gnt_n         = '1;
          owner_valid_n = 1'b0;
          timeout_n     = 1'b1;
          ptr_n         = owner_inc;
          state_n       = IDLE;
        end else begin
          counter_n = counter + 1'b1;
        end
      end
      // A preempted owner finishes its transaction without gnt; never re-granted here.
      BUSY: begin
        if (bus_idle) begin
          gnt_n         = '1;
          owner_valid_n = 1'b0;
          state_n       = IDLE;
        end else if (other_req) begin
          gnt_n         = '1;
          owner_valid_n = 1'b0;
        end
      end
      PARKED: begin
`ifdef ARB_PARK_EN
        if (!frame) begin
          state_n = BUSY;
          ptr_n   = owner_inc;
        end else if (other_req) begin
          gnt_n         = '1;
          owner_valid_n = 1'b0;
          state_n       = IDLE;
        end
`else
        gnt_n         = '1;
        owner_valid_n = 1'b0;
        state_n       = IDLE;
`endif
      end
      default: begin
        gnt_n         = '1;
        owner_valid_n = 1'b0;
        state_n       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '1;
      owner       <= '0;
      owner_valid <= 1'b0;
      timeout     <= 1'b0;
      ptr         <= '0;
      counter     <= '0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      owner       <= owner_n;
      owner_valid <= owner_valid_n;
      timeout     <= timeout_n;
      ptr         <= ptr_n;
      counter     <= counter_n;
    end
  end

endmodule
